// File: rtl/shift_share_arb.sv
// shift_share_arb: N requesters share one shift unit (shl, shr, ashl, ashr).
// Round-robin grant over valid/ready; each accepted request yields one
// registered response tagged with the requester index.
//
// Ports:
//   clk, rst_n           clock (rising edge), synchronous active-low reset
//   req_valid[N]         per-requester request valid
//   req_ready[N]         per-requester accept (one-hot or zero)
//   req_op[2N]           slice i = [2i+1:2i]: 00 shl, 01 shr, 10 ashl, 11 ashr
//   req_data[N*W]        slice i = [W*i+W-1:W*i]
//   req_amt[N*AW]        shift amount, 0..W-1
//   rsp_valid/rsp_ready  response handshake toward the consumer
//   rsp_id[IDW]          granted requester index
//   rsp_data[W]          shift result
//   busy                 high while a response is held (equals rsp_valid)
//
// Optional build macro: SHIFT_SHARE_ARB_PRIO0_EN
//   When defined, requester 0 wins whenever it is valid and a slot is free;
//   its grants leave rr_ptr untouched so 1..N-1 keep rotating among themselves.
module shift_share_arb #(
  parameter  int N   = 4,
  parameter  int W   = 8,
  localparam int AW  = $clog2(W),
  localparam int IDW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req_valid,
  output logic [N-1:0]      req_ready,
  input  logic [2*N-1:0]    req_op,
  input  logic [N*W-1:0]    req_data,
  input  logic [N*AW-1:0]   req_amt,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_data,
  output logic              busy
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;

  logic           can_accept;
  logic           any_valid;
  logic           accept;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] grant_hi, grant_lo;
  logic           found_hi;
  logic [1:0]     sel_op;
  logic [W-1:0]   sel_data;
  logic [AW-1:0]  sel_amt;
  logic [W-1:0]   shift_res;

  // Reset also masks ready so nothing looks accepted while rst_n is low.
  assign can_accept = rst_n && ((state == EMPTY) || (rsp_valid && rsp_ready));
  assign any_valid  = |req_valid;
  assign accept     = can_accept && any_valid;

  // Round-robin: lowest valid index above rr_ptr wins; if none, wrap to the
  // lowest valid index overall. Descending loops leave the lowest match.
  always_comb begin
    grant_hi = '0;
    grant_lo = '0;
    found_hi = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant_lo = IDW'(i);
        if (IDW'(i) > rr_ptr) begin
          grant_hi = IDW'(i);
          found_hi = 1'b1;
        end
      end
    end
    grant = found_hi ? grant_hi : grant_lo;
`ifdef SHIFT_SHARE_ARB_PRIO0_EN
    if (req_valid[0]) grant = '0;
`endif
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  // Operand mux for the single shared shifter.
  always_comb begin
    sel_op   = '0;
    sel_data = '0;
    sel_amt  = '0;
    for (int i = 0; i < N; i++) begin
      if (IDW'(i) == grant) begin
        sel_op   = req_op[2*i +: 2];
        sel_data = req_data[W*i +: W];
        sel_amt  = req_amt[AW*i +: AW];
      end
    end
  end

  // shl and ashl both zero-fill from the LSB.
  always_comb begin
    case (sel_op)
      2'b01:   shift_res = sel_data >> sel_amt;
      2'b11:   shift_res = W'($signed(sel_data) >>> sel_amt);
      default: shift_res = sel_data << sel_amt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= EMPTY;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rr_ptr    <= IDW'(N - 1);
    end else if (accept) begin
      // Covers the drain+accept case too: new response overwrites the old.
      state     <= FULL;
      rsp_valid <= 1'b1;
      busy      <= 1'b1;
      rsp_id    <= grant;
      rsp_data  <= shift_res;
`ifdef SHIFT_SHARE_ARB_PRIO0_EN
      if (grant != '0) rr_ptr <= grant;
`else
      rr_ptr    <= grant;
`endif
    end else if (rsp_valid && rsp_ready) begin
      state     <= EMPTY;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_share_arb.sv
module tb_shift_share_arb;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int AW  = $clog2(W);
  localparam int IDW = $clog2(N);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [2*N-1:0]    req_op;
  logic [N*W-1:0]    req_data;
  logic [N*AW-1:0]   req_amt;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_data;
  logic              busy;

  int compared = 0;
  int mismatched = 0;

  // Per-requester stimulus.
  logic [N-1:0] rv;
  int rop[N];
  int rdat[N];
  int ramt[N];

  // Reference model: the held response and the last round-robin winner.
  bit m_valid;
  int m_id, m_data, m_last;

  shift_share_arb #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_data(req_data), .req_amt(req_amt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_valid = rv;
    req_op    = '0;
    req_data  = '0;
    req_amt   = '0;
    for (int i = 0; i < N; i++) begin
      req_op[2*i +: 2]     = rop[i][1:0];
      req_data[W*i +: W]   = rdat[i][W-1:0];
      req_amt[AW*i +: AW]  = ramt[i][AW-1:0];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Shift result from plain arithmetic.
  function automatic int ref_shift(input int op, input int d, input int a);
    int p, full;
    p = 2 ** a;
    full = 2 ** W;
    case (op)
      1:       return d / p;
      3:       return d / p + ((d >= full / 2) ? (full - full / p) : 0);
      default: return (d * p) % full;
    endcase
  endfunction

  // Winner: valid requester at the smallest circular distance after m_last.
  function automatic int exp_grant();
    int best, bestd, d;
    best = -1;
    bestd = N + 1;
`ifdef SHIFT_SHARE_ARB_PRIO0_EN
    if (rv[0]) return 0;
`endif
    for (int i = 0; i < N; i++) begin
      if (rv[i]) begin
        d = (i - m_last - 1 + 2 * N) % N;
        if (d < bestd) begin
          bestd = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_id = 0;
    m_data = 0;
    m_last = N - 1;
  endtask

  // Called just after a falling edge with inputs set; checks all outputs,
  // crosses one rising edge, advances the model, returns the grant (or -1).
  task automatic step(output int g_acc);
    int g;
    bit can;
    logic [N-1:0] er;
    #1;
    g = exp_grant();
    can = rst_n && (!m_valid || rsp_ready);
    er = '0;
    if (can && g >= 0) er = N'(1) << g;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    chk("busy",      32'(busy),      32'(m_valid));
    chk("rsp_id",    32'(rsp_id),    m_id);
    chk("rsp_data",  32'(rsp_data),  m_data);
    @(posedge clk);
    g_acc = -1;
    if (!rst_n) model_reset();
    else if (can && g >= 0) begin
      m_valid = 1;
      m_id = g;
      m_data = ref_shift(rop[g], rdat[g], ramt[g]);
`ifdef SHIFT_SHARE_ARB_PRIO0_EN
      if (g != 0) m_last = g;
`else
      m_last = g;
`endif
      g_acc = g;
    end else if (m_valid && rsp_ready) m_valid = 0;
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input int op, input int d, input int a);
    rv[i] = 1'b1;
    rop[i] = op;
    rdat[i] = d;
    ramt[i] = a;
  endtask

  initial begin
    int g, id0, d0;
    int rr_exp[6] = '{0, 1, 2, 3, 0, 1};

    // Reset with every requester asserting valid.
    for (int i = 0; i < N; i++) set_req(i, 0, 8'h11 * (i + 1), 1);
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data",  32'(rsp_data),  0);
    chk("rst_rsp_id",    32'(rsp_id),    0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_busy",      32'(busy),      0);
    model_reset();
    rv = '0;
    rst_n = 1'b1;

    // Single shr from requester 0.
    set_req(0, 1, 8'h80, 3);
    step(g);
    rv = '0;
    chk("shr_valid", 32'(rsp_valid), 1);
    chk("shr_data",  32'(rsp_data),  32'h10);
    chk("shr_id",    32'(rsp_id),    0);
    step(g);
    chk("shr_drain", 32'(rsp_valid), 0);

    // Op coverage from requester 2.
    set_req(2, 3, 8'h80, 3);
    step(g);
    rv = '0;
    chk("ashr_data", 32'(rsp_data), 32'hF0);
    chk("ashr_id",   32'(rsp_id),   2);
    set_req(2, 2, 8'h81, 1);
    step(g);
    rv = '0;
    chk("ashl_data", 32'(rsp_data), 32'h02);
    set_req(2, 0, 8'h5A, 0);
    step(g);
    rv = '0;
    chk("shl0_data", 32'(rsp_data), 32'h5A);
    step(g);

    // Round-robin from a fresh reset, all requesters valid.
    rst_n = 1'b0;
    step(g);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, i % 4, 8'hA5 ^ i, i);
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step(g);
`ifndef SHIFT_SHARE_ARB_PRIO0_EN
      chk("rr_id", 32'(rsp_id), rr_exp[k]);
`endif
      chk("rr_nobubble", 32'(rsp_valid), 1);
    end

    // Backpressure holds everything; release picks the successor.
    id0 = int'(rsp_id);
    d0 = int'(rsp_data);
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(g);
      chk("bp_id",    32'(rsp_id),    id0);
      chk("bp_data",  32'(rsp_data),  d0);
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_ready", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    step(g);
`ifndef SHIFT_SHARE_ARB_PRIO0_EN
    chk("bp_next_id", 32'(rsp_id), (id0 + 1) % N);
`endif

`ifdef SHIFT_SHARE_ARB_PRIO0_EN
    rv = '0;
    set_req(0, 0, 8'h01, 1);
    set_req(3, 1, 8'h80, 1);
    for (int k = 0; k < 4; k++) begin
      step(g);
      chk("prio_id0", 32'(rsp_id), 0);
    end
    rv[0] = 1'b0;
    step(g);
    chk("prio_id3", 32'(rsp_id), 3);
`endif

    // Randomized traffic with occasional mid-operation resets.
    rv = '0;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++)
        if (!rv[i] && $urandom_range(0, 1) == 1)
          set_req(i, $urandom_range(0, 3), $urandom_range(0, 2**W - 1), $urandom_range(0, W - 1));
      rsp_ready = ($urandom_range(0, 9) < 7);
      rst_n = ($urandom_range(0, 63) != 0);
      step(g);
      if (g >= 0) rv[g] = 1'b0;
    end
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/shift_share_arb.md
Name: shift_share_arb

Overview:
- Shares one shift unit between N requesters. The unit supports logical <<, logical >>, arithmetic <<< and arithmetic >>>.
- Requesters are granted round-robin over a valid/ready handshake.
- Each accepted request produces one registered response, tagged with the requester id.
- Sits between per-channel producers and a single downstream consumer. The consumer can apply backpressure.

Parameters:
- N, 4, number of requesters (2..16).
- W, 8, data width (power of two, ≥2).
- AW, $clog2(W), shift-amount width. Derived; do not override.
- IDW, $clog2(N), response id width. Derived; do not override.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active low
- req_valid  in  N  per-requester request valid
- req_ready  out  N  per-requester accept; one-hot or zero
- req_op  in  2N  per-requester op, slice i = [2i+1:2i]: 00 shl, 01 shr, 10 ashl, 11 ashr
- req_data  in  N*W  per-requester operand, slice i = [W*i+W-1:W*i]
- req_amt  in  N*AW  per-requester shift amount, 0..W-1
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accept
- rsp_id  out  IDW  index of the granted requester
- rsp_data  out  W  shift result
- busy  out  1  high while a response is held (state FULL)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low, sampled on the rising edge of clk.
- Reset values: rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, state=EMPTY, rr_ptr=N-1 (so requester 0 wins first).
- States:
  - EMPTY: no response held.
  - FULL: response held on rsp_*.
- can_accept = (state==EMPTY) | (rsp_valid & rsp_ready).
- Arbitration (combinational):
  - Search req_valid starting at index rr_ptr+1, wrapping modulo N. The first set bit is grant g.
  - req_ready[g] = can_accept & req_valid[g]. All other req_ready bits are 0.
- Accept (req_valid[g] & req_ready[g] at clk edge):
  - Compute the result and capture it on the same edge: rsp_data <= shift(op,data,amt), rsp_id <= g.
  - rsp_valid <= 1, state <= FULL, rr_ptr <= g.
  - Latency: accept edge → rsp_valid on the next cycle.
- Drain without new accept: rsp_valid & rsp_ready and no req_valid → rsp_valid <= 0, state <= EMPTY. rsp_id and rsp_data keep their last values.
- Simultaneous drain and accept: the new response replaces the old on the same edge. rsp_valid stays 1, giving throughput 1/cycle.
- Backpressure: while rsp_valid & !rsp_ready:
  - rsp_id and rsp_data stay stable.
  - All req_ready = 0.
  - rr_ptr is unchanged.
- Shift rules:
  - shl and ashl are identical: zero fill from the LSB.
  - shr: zero fill from the MSB.
  - ashr: fill with data[W-1].
  - amt=0 passes data through unchanged.
  - Result is truncated to W bits.
- Fairness: a requester holding req_valid high is granted within N accepts.
- Requester protocol: req_valid and payload must stay stable until req_ready. The arbiter does not check this.
- Reset mid-operation: a held response is discarded. All outputs return to reset values on the edge where rst_n=0, regardless of rsp_ready.
- busy = (state==FULL). It always equals rsp_valid.

Optional Feature:
- Macro: SHIFT_SHARE_ARB_PRIO0_EN.
- Defined:
  - Requester 0 wins whenever req_valid[0]=1 and can_accept, overriding round-robin.
  - A requester-0 grant does not update rr_ptr. Requesters 1..N-1 keep round-robin among themselves.
- Undefined: pure round-robin; requester 0 has no special treatment.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with all req_valid=1 → rsp_valid=0, rsp_data=0, rsp_id=0, req_ready=0, busy=0.
- Single shr: req 0: op=01, data=8'h80, amt=3, rsp_ready=1 → next cycle rsp_valid=1, rsp_data=8'h10, rsp_id=0. Then rsp_valid=0.
- Ops: req 2 ashr 8'h80 amt 3 → 8'hF0, id=2. ashl 8'h81 amt 1 → 8'h02. shl amt 0 of 8'h5A → 8'h5A.
- Round-robin: all four req_valid held, rsp_ready=1 → rsp_id sequence 0,1,2,3,0,1 on consecutive cycles, no bubbles.
- Backpressure: rsp_ready=0 for 5 cycles while FULL → rsp_id, rsp_data and rsp_valid unchanged, req_ready=0. On the rsp_ready=1 edge the next grant is the round-robin successor.
- Prio (macro defined): req 0 and req 3 continuously valid → id 0 every cycle. Drop req 0 → id 3.
